// File: rtl/mfp_pmod_spi_sample_scheduler.sv
// mfp_pmod_spi_sample_scheduler
//   Periodic sampler for up to four PMOD serial ADC sensors sharing one SCK.
//   Every SAMPLE_PERIOD clocks (while enable=1) a round is requested. A round
//   frames channel 0..CHANNELS-1 in turn. Each frame is SETUP (SCK high, CS low),
//   FRAME_BITS SCK periods (low half then high half, MSB first), and HOLD
//   (all CS high). On completion of a frame the channel's value register is
//   loaded and its valid bit pulses.
//
//   Optional feature macro: MFP_SPI_SCHED_TRIGGER_EN
//     When defined, a `trigger` input requests a round like a timer tick, and a
//     triggered round starts even with enable=0.
//
//   Output handshake: valid[c] is a single-cycle strobe with no ready. value
//   for channel c changes only on the cycle valid[c] is high and holds the
//   whole frame word until the next strobe, so a reader may sample the
//   register at any time without seeing a partial frame.
module mfp_pmod_spi_sample_scheduler #(
  parameter int CHANNELS      = 2,
  parameter int FRAME_BITS    = 16,
  parameter int SCK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
`ifdef MFP_SPI_SCHED_TRIGGER_EN
  input  logic                           trigger,
`endif
  output logic [CHANNELS-1:0]            spi_cs_n,
  output logic                           spi_sck,
  input  logic [CHANNELS-1:0]            spi_sdo,
  output logic [CHANNELS*FRAME_BITS-1:0] value,
  output logic [CHANNELS-1:0]            valid,
  output logic                           busy,
  output logic                           overrun
);

  // Counter widths sized from the parameters.
  localparam int TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CNT_W   = $clog2(2 * SCK_DIV);
  localparam int BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0]   HALF_LAST   = CNT_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0]   HALF        = CNT_W'(SCK_DIV);
  localparam logic [CNT_W-1:0]   PERIOD_LAST = CNT_W'(2 * SCK_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST    = BIT_W'(FRAME_BITS - 1);
  localparam logic [CH_W-1:0]    CH_LAST     = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_d;
  logic [TIMER_W-1:0]      timer;
  logic                    tick;
  logic                    req;
  logic                    pending;
  logic                    start_ok;
  logic                    start;
  logic [CH_W-1:0]         ch;
  logic [CH_W-1:0]         ch_d;
  logic [BIT_W-1:0]        bit_cnt;
  logic [BIT_W-1:0]        bit_d;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_d;
  logic                    sample;
  logic                    frame_done;
  logic                    sdo_bit;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [CHANNELS-1:0]     cs_n_d;
  logic                    sck_d;

  // Wrap point of the period timer; no ticks while disabled.
  assign tick = enable && (timer == TIMER_LAST);

`ifdef MFP_SPI_SCHED_TRIGGER_EN
  // Remembers that the pending request came from trigger so it may start
  // while enable is low.
  logic pend_trig;

  assign req      = tick | trigger;
  assign start_ok = enable | pend_trig;

  // Trigger-origin flag: set by trigger, consumed when a round starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_trig <= 1'b0;
    end else begin
      pend_trig <= trigger | (pend_trig & ~start);
    end
  end
`else
  assign req      = tick;
  assign start_ok = enable;
`endif

  assign start = (state == IDLE) && pending && start_ok;

  // Period timer: counts while enabled, parks at zero when disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (!enable || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Single-entry request flag; a request landing on an occupied flag is
  // reported as overrun and dropped. A request arriving on the very cycle a
  // round starts becomes the next pending request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pending <= req | (pending & ~start);
      overrun <= req & pending & ~start;
    end
  end

  // FSM state and frame counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ch      <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_d;
      ch      <= ch_d;
      bit_cnt <= bit_d;
      cnt     <= cnt_d;
    end
  end

  // Next-state logic. cnt walks one SCK half in SETUP/HOLD and one full SCK
  // period in SHIFT (low half at 0..SCK_DIV-1, high half above).
  always_comb begin
    state_d    = state;
    ch_d       = ch;
    bit_d      = bit_cnt;
    cnt_d      = cnt;
    sample     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          ch_d    = '0;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt == HALF_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT: begin
        // First cycle of the high half is the cycle SCK rises.
        sample = (cnt == HALF);
        if (cnt == PERIOD_LAST) begin
          cnt_d = '0;
          if (bit_cnt == BIT_LAST) begin
            state_d    = HOLD;
            frame_done = 1'b1;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cnt == HALF_LAST) begin
          cnt_d = '0;
          if (ch == CH_LAST) begin
            state_d = IDLE;
          end else begin
            state_d = SETUP;
            ch_d    = ch + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin decode from the next state so CS and SCK come straight from flops.
  always_comb begin
    cs_n_d = '1;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((state_d == SETUP || state_d == SHIFT) && ch_d == CH_W'(c)) begin
        cs_n_d[c] = 1'b0;
      end
    end
    sck_d = !(state_d == SHIFT && cnt_d < HALF);
  end

  // Select the SDO line of the channel being framed.
  always_comb begin
    sdo_bit = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch == CH_W'(c)) begin
        sdo_bit = spi_sdo[c];
      end
    end
  end

  // Registered pin drivers and round-in-progress flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spi_cs_n <= '1;
      spi_sck  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      spi_cs_n <= cs_n_d;
      spi_sck  <= sck_d;
      busy     <= (state_d != IDLE);
    end
  end

  // Frame shift register, MSB arrives first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (sample) begin
      shift_reg <= {shift_reg[FRAME_BITS-2:0], sdo_bit};
    end
  end

  // Whole-frame update of the channel value register plus its strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
      valid <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        valid[c] <= frame_done && (ch == CH_W'(c));
        if (frame_done && ch == CH_W'(c)) begin
          value[c*FRAME_BITS +: FRAME_BITS] <= shift_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_mfp_pmod_spi_sample_scheduler.sv
// Bench for mfp_pmod_spi_sample_scheduler (CHANNELS=2, 16-bit frames,
// SCK_DIV=4, SAMPLE_PERIOD=100 so rounds of 272 cycles run back to back).
// Sensor models push the word they are about to shift out into exp_q when
// their CS falls; a monitor pops on every valid strobe and compares.
// Timing expectations, counted in clock edges after reset release:
//   tick in cycle after edge 99 -> pending at 100 -> CS0 low from edge 101
//   CS low = SETUP 4 + SHIFT 16*8 = 132 cycles -> valid0 at edge 233
//   per-channel frame 136 cycles -> valid1 at edge 369, IDLE at 373,
//   next round CS0 low from edge 374; overruns at edges 300, 500, 600.
module tb_mfp_pmod_spi_sample_scheduler;
  localparam int CHANNELS = 2;
  localparam int FB       = 16;
  localparam int DIV      = 4;
  localparam int PERIOD   = 100;
  localparam int CS_LOW   = DIV + 2 * FB * DIV;          // 132
  localparam int FRAME    = (2 + 2 * FB) * DIV;          // 136
  localparam int FIRST_V0 = PERIOD + 1 + CS_LOW;         // 233
  localparam logic [15:0] TBL [2][4] = '{
    '{16'h0A5C, 16'hFFFF, 16'h0000, 16'h8001},
    '{16'h1234, 16'hA5A5, 16'h7FFE, 16'h0001}
  };

  // ---------------- clock / reset ----------------
  logic                     clock = 1'b0;
  logic                     reset;
  logic                     enable;
`ifdef MFP_SPI_SCHED_TRIGGER_EN
  logic                     trigger;
`endif
  logic [CHANNELS-1:0]      spi_cs_n;
  logic                     spi_sck;
  logic [CHANNELS-1:0]      spi_sdo;
  logic [CHANNELS*FB-1:0]   value;
  logic [CHANNELS-1:0]      valid;
  logic                     busy;
  logic                     overrun;

  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  mfp_pmod_spi_sample_scheduler #(
    .CHANNELS(CHANNELS), .FRAME_BITS(FB), .SCK_DIV(DIV), .SAMPLE_PERIOD(PERIOD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
`ifdef MFP_SPI_SCHED_TRIGGER_EN
    .trigger  (trigger),
`endif
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_sdo  (spi_sdo),
    .value    (value),
    .valid    (valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
  endtask

  // ---------------- sensor models ----------------
  // Output bit k of the word after the (k+1)-th SCK fall in the frame; the
  // DUT samples it SCK_DIV cycles later on the rising half.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_sensor
    logic [15:0] cur_word = 16'h0;
    int          frame_no = 0;
    int          falls    = 0;
    always @(negedge spi_cs_n[g]) begin
      cur_word = TBL[g][frame_no % 4];
      frame_no++;
      falls = 0;
      exp_q.push_back({1'(g), cur_word});
    end
    always @(negedge spi_sck) begin
      if (!spi_cs_n[g]) falls++;
    end
    assign spi_sdo[g] = (falls >= 1 && falls <= FB) ? cur_word[FB - falls] : 1'b0;
  end

  // ---------------- monitor ----------------
  int first_valid [CHANNELS];
  int npop = 0;
  int ovr_cnt = 0;
  int overlap_err = 0;
  int idle_sck_err = 0;
  int hold_err = 0;
  int cs0_fall_cyc[$];
  logic prev_cs0 = 1'b1;
  logic [CHANNELS*FB-1:0] prev_value = '0;

  always @(negedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) first_valid[c] = -1;
      prev_value = value;
      prev_cs0   = 1'b1;
    end else begin
      if (spi_cs_n == 2'b00) overlap_err++;
      if (&spi_cs_n && spi_sck !== 1'b1) idle_sck_err++;
      if (valid == '0 && value !== prev_value) hold_err++;
      if (overrun) ovr_cnt++;
      if (prev_cs0 && !spi_cs_n[0]) cs0_fall_cyc.push_back(cyc);
      prev_cs0   = spi_cs_n[0];
      prev_value = value;
      for (int c = 0; c < CHANNELS; c++) begin
        if (valid[c]) begin
          if (first_valid[c] < 0) first_valid[c] = cyc;
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_valid_ch%0d", c), 32'(valid), 32'h0);
          end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            npop++;
            check($sformatf("valid_channel_order_ch%0d", c), 32'(c), 32'(e[16]));
            check($sformatf("value_ch%0d", c), 32'(value[c*FB +: FB]), 32'(e[15:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cs_fall(input int ch, input int limit, output bit ok);
    int n = 0;
    while (spi_cs_n[ch] == 1'b0 && n < limit) begin @(negedge clock); n++; end
    while (spi_cs_n[ch] == 1'b1 && n < limit) begin @(negedge clock); n++; end
    ok = (spi_cs_n[ch] == 1'b0);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin @(negedge clock); n++; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int n;
    int bad;
    int nfalls;
    int run;
    int act;
    int fcyc;
    logic ps;

    reset  = 1'b1;
    enable = 1'b0;
`ifdef MFP_SPI_SCHED_TRIGGER_EN
    trigger = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check("reset_cs_n",    32'(spi_cs_n), 32'h3);
    check("reset_sck",     32'(spi_sck),  32'h1);
    check("reset_value",   32'(value),    32'h0);
    check("reset_valid",   32'(valid),    32'h0);
    check("reset_busy",    32'(busy),     32'h0);
    check("reset_overrun", 32'(overrun),  32'h0);

    // Rounds back to back with overruns; inspect the first ch0 frame.
    enable = 1'b1;
    reset  = 1'b0;
    wait_cs_fall(0, 300, ok);
    check("cs0_first_fall_seen", 32'(ok), 32'h1);
    check("cs0_first_fall_cycle", 32'(cyc), 32'(PERIOD + 1));
    check("busy_in_round", 32'(busy), 32'h1);
    n = 0; run = 0; bad = 0; nfalls = 0;
    ps = spi_sck;
    while (spi_cs_n[0] == 1'b0 && n < 400) begin
      n++;
      run++;
      @(negedge clock);
      if (spi_sck !== ps) begin
        if (run != DIV) bad++;
        if (ps == 1'b1) nfalls++;
        run = 0;
        ps = spi_sck;
      end
    end
    if (run != DIV) bad++;
    check("cs0_low_cycles", 32'(n), 32'(CS_LOW));
    check("sck_half_period_errors", 32'(bad), 32'h0);
    check("sck_falls_per_frame", 32'(nfalls), 32'(FB));

    n = 0;
    while (cyc < 700 && n < 1000) begin @(negedge clock); n++; end
    check("first_valid0_cycle", 32'(first_valid[0]), 32'(FIRST_V0));
    check("first_valid1_cycle", 32'(first_valid[1]), 32'(FIRST_V0 + FRAME));
    check("overruns_by_700", 32'(ovr_cnt), 32'h3);
    check("values_by_700", 32'(npop), 32'h4);
    if (cs0_fall_cyc.size() >= 2) check("round2_cs0_fall_cycle", 32'(cs0_fall_cyc[1]), 32'(PERIOD + 1 + 2 * FRAME + 1));
    else check("round2_cs0_fall_seen", 32'(cs0_fall_cyc.size()), 32'h2);

    // Drop enable during ch0 SHIFT of round 4: the round still finishes.
    wait_cs_fall(0, 400, ok);
    check("round4_cs0_fall_seen", 32'(ok), 32'h1);
    repeat (40) @(negedge clock);
    enable = 1'b0;
    wait_idle(500);
    check("busy_fell_after_disable", 32'(busy), 32'h0);
    check("round4_both_values", 32'(npop), 32'h8);
    check("queue_empty_after_disable", 32'(exp_q.size()), 32'h0);
    act = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (spi_cs_n != 2'b11 || busy) act++;
    end
    check("no_activity_while_disabled", 32'(act), 32'h0);

    // Reset during bit 7 of ch1.
    enable = 1'b1;
    wait_cs_fall(1, 600, ok);
    check("ch1_fall_seen", 32'(ok), 32'h1);
    repeat (2 + 7 * 2 * DIV) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midframe_reset_cs_n",  32'(spi_cs_n), 32'h3);
    check("midframe_reset_sck",   32'(spi_sck),  32'h1);
    check("midframe_reset_value", 32'(value),    32'h0);
    check("midframe_reset_valid", 32'(valid),    32'h0);
    check("midframe_reset_busy",  32'(busy),     32'h0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n = 0;
    while (first_valid[0] < 0 && n < 400) begin @(negedge clock); n++; end
    check("post_reset_first_valid0", 32'(first_valid[0]), 32'(FIRST_V0));
    enable = 1'b0;
    wait_idle(500);
    check("busy_fell_after_reset_round", 32'(busy), 32'h0);
    check("queue_empty_after_reset_round", 32'(exp_q.size()), 32'h0);

`ifdef MFP_SPI_SCHED_TRIGGER_EN
    // Triggered rounds with enable low; a second trigger adds one round.
    n = cs0_fall_cyc.size();
    @(negedge clock); trigger = 1'b1;
    @(negedge clock); trigger = 1'b0;
    wait_cs_fall(0, 50, ok);
    check("trigger_round_started", 32'(ok), 32'h1);
    fcyc = cyc;
    repeat (20) @(negedge clock);
    trigger = 1'b1;
    @(negedge clock); trigger = 1'b0;
    run = 0;
    while (!valid[0] && run < 300) begin @(negedge clock); run++; end
    check("trigger_valid0_delay", 32'(cyc - fcyc), 32'(CS_LOW));
    repeat (900) @(negedge clock);
    check("trigger_round_count", 32'(cs0_fall_cyc.size() - n), 32'h2);
    check("busy_idle_after_triggers", 32'(busy), 32'h0);
    check("queue_empty_after_triggers", 32'(exp_q.size()), 32'h0);
`else
    fcyc = 0;
`endif

    check("cs_overlap_samples", 32'(overlap_err), 32'h0);
    check("sck_low_while_deselected", 32'(idle_sck_err), 32'h0);
    check("value_changed_without_valid", 32'(hold_err), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #2000000;
    check("global_timeout", 32'h1, 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
